// File: rtl/pixel_readout_sequencer_pkg.sv
// ============================================================================
// Module      : pixel_seq_pkg
// Description : Shared types, constants and Gray-code helpers for the pixel
//               readout sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } seq_state_e;

    // Length of the array erase strobe in clock cycles
    localparam int ERASE_CYCLES = 4;

    // Helpers operate on a zero-extended container so one definition serves
    // every code width up to CODE_W; callers cast to their own width.
    localparam int CODE_W = 32;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
        logic [CODE_W-1:0] bin;
        bin[CODE_W-1] = gray[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_readout_sequencer_if.sv
// ============================================================================
// Module      : pixel_readout_sequencer_if
// Description : Output beat stream (valid/ready) between sequencer and consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_readout_sequencer_if #(
    parameter int BEAT_WIDTH = 100
);
    logic [BEAT_WIDTH-1:0] DATA_OUT;
    logic                  DATA_OUT_VALID;
    logic                  DATA_OUT_READY;
    logic                  FRAME_END;

    modport master (
        output DATA_OUT,
        output DATA_OUT_VALID,
        output FRAME_END,
        input  DATA_OUT_READY
    );

    modport slave (
        input  DATA_OUT,
        input  DATA_OUT_VALID,
        input  FRAME_END,
        output DATA_OUT_READY
    );
endinterface

`default_nettype wire

// File: rtl/pixel_readout_sequencer_gray2bin.sv
// ============================================================================
// Module      : pixel_gray2bin
// Description : Single-pixel Gray-to-binary converter (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_gray2bin
    import pixel_seq_pkg::*;
#(
    parameter int W = 10
) (
    input  wire logic [W-1:0] gray_i,
    output logic      [W-1:0] bin_o
);

    assign bin_o = W'(gray2bin(CODE_W'(gray_i)));

endmodule

`default_nettype wire

// File: rtl/pixel_readout_sequencer.sv
// ============================================================================
// Module      : pixel_readout_sequencer
// Description : Erase -> expose -> convert -> readout frame sequencer for the
//               digital pixel array, streaming pixels over valid/ready.
//               Optional macro PIXEL_GRAY_COUNTER_EN selects a Gray-coded
//               conversion counter with Gray->binary conversion on readout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_readout_sequencer
    import pixel_seq_pkg::*;
#(
    parameter int WIDTH                  = 100,
    parameter int HEIGHT                 = 100,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 10,
    parameter int BIT_DEPTH              = 10,
    parameter int EXPOSURE_BITS          = 16,
    localparam int GROUPS = WIDTH / OUTPUT_BUS_PIXEL_WIDTH,
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int BEAT_W = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH
) (
    input  wire logic                     SYSTEM_CLK,
    input  wire logic                     SYSTEM_RESET_N,
    input  wire logic                     START,
    input  wire logic                     CONTINUOUS,
    input  wire logic [EXPOSURE_BITS-1:0] EXPOSURE_CYCLES,
    output logic                          PIXEL_ERASE,
    output logic                          PIXEL_EXPOSE,
    output logic                          ADC_RAMP_EN,
    output logic      [BIT_DEPTH-1:0]     COUNTER_VALUE,
    output logic      [ROW_W-1:0]         READ_ROW,
    output logic      [GRP_W-1:0]         READ_GROUP,
    input  wire logic [BEAT_W-1:0]        READ_DATA,
    output logic                          BUSY,
    pixel_readout_sequencer_if.master     bus
);

    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_ERASE   = 3'(ST_ERASE);
    localparam logic [2:0] S_EXPOSE  = 3'(ST_EXPOSE);
    localparam logic [2:0] S_CONVERT = 3'(ST_CONVERT);
    localparam logic [2:0] S_READ    = 3'(ST_READ);

    localparam int                  TMR_W      = (EXPOSURE_BITS > 3) ? EXPOSURE_BITS : 3;
    localparam logic [TMR_W-1:0]    ERASE_LOAD = TMR_W'(ERASE_CYCLES - 1);
    localparam logic [BIT_DEPTH-1:0] CNT_MAX   = '1;
    localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(HEIGHT - 1);
    localparam logic [GRP_W-1:0]    GRP_LAST   = GRP_W'(GROUPS - 1);

    // A row must split into whole beats
    if (WIDTH % OUTPUT_BUS_PIXEL_WIDTH != 0) begin : g_width_check
        $error("WIDTH must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
    end

    logic [2:0]           state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [BIT_DEPTH-1:0] cnt_q, cnt_d;
    logic [BIT_DEPTH-1:0] cv_q, cv_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [GRP_W-1:0]     grp_q, grp_d;
    logic [BEAT_W-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fend_q, fend_d;
    logic                 loaded_q, loaded_d;
    logic                 erase_q, expose_q, ramp_q, busy_q;

    logic [TMR_W-1:0]     w_exp_load;
    logic [BEAT_W-1:0]    w_read_conv;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_last_addr;

    // Exposure of 0 behaves as 1 cycle; the timer counts down to zero
    assign w_exp_load = (EXPOSURE_CYCLES == '0) ? '0 : TMR_W'(EXPOSURE_CYCLES - 1'b1);

    assign w_accept    = valid_q & bus.DATA_OUT_READY;
    assign w_load      = (state_q == S_READ) & ~loaded_q & (~valid_q | bus.DATA_OUT_READY);
    assign w_last_addr = (row_q == ROW_LAST) & (grp_q == GRP_LAST);

`ifdef PIXEL_GRAY_COUNTER_EN
    // Pixel latches capture Gray codes; decode each pixel before output
    for (genvar gi = 0; gi < OUTPUT_BUS_PIXEL_WIDTH; gi++) begin : g_gray
        pixel_gray2bin #(.W(BIT_DEPTH)) u_g2b (
            .gray_i (READ_DATA[gi*BIT_DEPTH +: BIT_DEPTH]),
            .bin_o  (w_read_conv[gi*BIT_DEPTH +: BIT_DEPTH])
        );
    end
    assign cv_d = BIT_DEPTH'(bin2gray(CODE_W'(cnt_d)));
`else
    assign w_read_conv = READ_DATA;
    assign cv_d        = cnt_d;
`endif

    // Next-state logic: phase sequencing, conversion count and readout stream
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        grp_d    = grp_q;
        data_d   = data_q;
        valid_d  = valid_q;
        fend_d   = fend_q;
        loaded_d = loaded_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_ERASE;
                    tmr_d   = ERASE_LOAD;
                end
            end
            S_ERASE: begin
                if (tmr_q == '0) begin
                    state_d = S_EXPOSE;
                    tmr_d   = w_exp_load;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_EXPOSE: begin
                if (tmr_q == '0) begin
                    state_d = S_CONVERT;
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_CONVERT: begin
                if (cnt_q == CNT_MAX) begin
                    state_d  = S_READ;
                    cnt_d    = '0;
                    row_d    = '0;
                    grp_d    = '0;
                    loaded_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                if (w_accept) begin
                    valid_d = 1'b0;
                    fend_d  = 1'b0;
                    if (fend_q) begin
                        loaded_d = 1'b0;
                        if (CONTINUOUS) begin
                            state_d = S_ERASE;
                            tmr_d   = ERASE_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                // A load in the same cycle as an accept refills the register
                if (w_load) begin
                    data_d  = w_read_conv;
                    valid_d = 1'b1;
                    fend_d  = w_last_addr;
                    if (w_last_addr) begin
                        loaded_d = 1'b1;
                    end
                    if (grp_q == GRP_LAST) begin
                        grp_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; strobes decoded from next state so they align with it
    always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            cnt_q    <= '0;
            cv_q     <= '0;
            row_q    <= '0;
            grp_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            fend_q   <= 1'b0;
            loaded_q <= 1'b0;
            erase_q  <= 1'b0;
            expose_q <= 1'b0;
            ramp_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            cv_q     <= cv_d;
            row_q    <= row_d;
            grp_q    <= grp_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            fend_q   <= fend_d;
            loaded_q <= loaded_d;
            erase_q  <= (state_d == S_ERASE);
            expose_q <= (state_d == S_EXPOSE);
            ramp_q   <= (state_d == S_CONVERT);
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign PIXEL_ERASE        = erase_q;
    assign PIXEL_EXPOSE       = expose_q;
    assign ADC_RAMP_EN        = ramp_q;
    assign COUNTER_VALUE      = cv_q;
    assign READ_ROW           = row_q;
    assign READ_GROUP         = grp_q;
    assign BUSY               = busy_q;
    assign bus.DATA_OUT       = data_q;
    assign bus.DATA_OUT_VALID = valid_q;
    assign bus.FRAME_END      = fend_q;

endmodule

`default_nettype wire

// File: doc/pixel_readout_sequencer.md
# pixel_readout_sequencer

Parametrised frame sequencer for the digital pixel sensor array. It drives the erase → expose → convert → readout cycle from one system clock, with programmable exposure and single-shot or continuous frame mode. It streams the array contents out as OUTPUT_BUS_PIXEL_WIDTH pixels per beat over a valid/ready handshake, so a downstream consumer can apply backpressure. It sits between the pixel array (control and read-address side) and the output bus of the top level.

## Interface
- WIDTH, 100, pixels per row; must be a multiple of OUTPUT_BUS_PIXEL_WIDTH (elaboration error otherwise)
- HEIGHT, 100, rows per frame
- OUTPUT_BUS_PIXEL_WIDTH, 10, pixels per output beat
- BIT_DEPTH, 10, bits per pixel and conversion counter width
- EXPOSURE_BITS, 16, width of EXPOSURE_CYCLES
- SYSTEM_CLK  in  1  the single clock; all logic is on its rising edge
- SYSTEM_RESET_N  in  1  asynchronous, active-low reset
- START  in  1  frame request; sampled only in IDLE
- CONTINUOUS  in  1  1 = start the next frame automatically after FRAME_END; sampled at the last beat
- EXPOSURE_CYCLES  in  EXPOSURE_BITS  exposure length; sampled on entry to EXPOSE; 0 is treated as 1
- PIXEL_ERASE  out  1  array erase strobe
- PIXEL_EXPOSE  out  1  array expose enable
- ADC_RAMP_EN  out  1  ramp/comparator enable
- COUNTER_VALUE  out  BIT_DEPTH  conversion counter broadcast to the pixel latches
- READ_ROW  out  $clog2(HEIGHT)  array read row
- READ_GROUP  out  $clog2(WIDTH/OUTPUT_BUS_PIXEL_WIDTH)  column group within READ_ROW
- READ_DATA  in  OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH  array data for (READ_ROW, READ_GROUP); combinational from the address
- DATA_OUT  out  OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH  output beat; pixel 0 (lowest column) in the LSBs
- DATA_OUT_VALID  out  1  beat valid
- DATA_OUT_READY  in  1  consumer accepts the beat
- FRAME_END  out  1  marks the last beat of the frame; qualified by VALID
- BUSY  out  1  state is not IDLE

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ.
- IDLE → ERASE when START=1. START is ignored in all other states.
- ERASE: PIXEL_ERASE=1 for ERASE_CYCLES (package constant, 4), then → EXPOSE.
- EXPOSE: PIXEL_EXPOSE=1 for max(EXPOSURE_CYCLES,1) cycles, then → CONVERT.
- CONVERT: ADC_RAMP_EN=1 for 2^BIT_DEPTH cycles. COUNTER_VALUE steps 0 → 2^BIT_DEPTH−1, advancing one per cycle. Then → READ, and COUNTER_VALUE returns to 0.
- READ: a single output register. It loads READ_DATA when empty, or when the current beat is accepted (VALID & READY). Each load advances the address: READ_GROUP increments; on its wrap it returns to 0 and READ_ROW increments.
- Total beats per frame: HEIGHT*WIDTH/OUTPUT_BUS_PIXEL_WIDTH.
- The last beat carries FRAME_END=1. When it is accepted: if CONTINUOUS=1, → ERASE; otherwise → IDLE. READ_ROW and READ_GROUP return to 0.
- While VALID=1 and READY=0: DATA_OUT and FRAME_END hold stable and the address holds.
- Reset (at any time, including mid-frame): state returns to IDLE and all outputs go to 0. The in-flight frame is discarded with no partial FRAME_END.

## Timing
- START high at edge N → PIXEL_ERASE high from cycle N+1 through N+4.
- PIXEL_EXPOSE is high from N+5 through N+4+E, where E = max(EXPOSURE_CYCLES,1).
- ADC_RAMP_EN is high for the next 2^BIT_DEPTH cycles.
- The first DATA_OUT_VALID occurs one cycle after entry to READ (registered output).
- With READY held at 1: one beat per cycle, no bubbles. Consecutive frames in CONTINUOUS mode have no idle cycle between the last beat and ERASE.
- At most one control strobe (ERASE/EXPOSE/RAMP_EN) is high at a time, and none is high during READ or IDLE.
- Outputs are registered, with no combinational path from DATA_OUT_READY to DATA_OUT_VALID.

## Configuration
- PIXEL_GRAY_COUNTER_EN defined:
  - COUNTER_VALUE is Gray-coded (bin ^ bin>>1).
  - Each BIT_DEPTH slice of READ_DATA is converted Gray→binary before it is loaded into DATA_OUT.
  - Latency is unchanged.
- PIXEL_GRAY_COUNTER_EN undefined:
  - COUNTER_VALUE is plain binary.
  - READ_DATA passes to DATA_OUT unmodified.

## Structure
- Package pixel_seq_pkg contains:
  - the state enum
  - the ERASE_CYCLES constant
  - bin2gray/gray2bin functions parametrised on width
- Sub-module pixel_gray2bin: one BIT_DEPTH-wide converter, instantiated OUTPUT_BUS_PIXEL_WIDTH times in a generate loop under the macro.

## Test plan
Common parameters: WIDTH=4, HEIGHT=2, OUTPUT_BUS_PIXEL_WIDTH=2, BIT_DEPTH=3.
- Single shot with EXPOSURE_CYCLES=5, READY=1:
  - ERASE for 4 cycles, EXPOSE for 5, RAMP_EN for 8 with COUNTER 0..7.
  - Then 4 beats at addresses (0,0),(0,1),(1,0),(1,1); FRAME_END on beat 4; BUSY falls after it.
- EXPOSURE_CYCLES=0 → EXPOSE lasts exactly 1 cycle.
- Backpressure: READY toggles 1,0,0,1,... → DATA_OUT stable during stalls; exactly 4 beats, none dropped or duplicated.
- CONTINUOUS=1 → PIXEL_ERASE rises in the cycle after the FRAME_END beat is accepted; second frame identical in length to the first.
- SYSTEM_RESET_N pulsed low during CONVERT → all outputs 0 immediately; IDLE; a new START yields a full clean frame.
- With PIXEL_GRAY_COUNTER_EN: COUNTER sequence 0,1,3,2,6,7,5,4; READ_DATA slice 3'b110 → DATA_OUT slice 3'b100.
